// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed driver for an N-digit 7-segment display
// and a ROWS x COLS LED matrix. A slot prescaler steps both scan indices.
// Each slot opens with BLANK cycles where all enables are off. Frame data is
// double-buffered so a new frame is only picked up at a frame boundary.
module disp_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int ROWS     = 7,
    parameter int COLS     = 5,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [4*N_DIGITS-1:0]    digit_data,
    input  logic                     digit_load,
    input  logic [ROWS*COLS-1:0]     matrix_data,
    input  logic                     matrix_load,
    output logic [7:0]               seg_out,
    output logic [N_DIGITS-1:0]      digit_en,
    output logic [ROWS-1:0]          mat_row,
    output logic [COLS-1:0]          mat_col_en,
    output logic                     dig_frame,
    output logic                     mat_frame,
    output logic                     dig_pending,
    output logic                     mat_pending
);

    localparam int TW = $clog2(PRESCALE);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [TW-1:0] T_LAST   = TW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(N_DIGITS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    // Scan state
    logic [TW-1:0] t_q, t_d;
    logic [DW-1:0] dig_idx_q, dig_idx_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic          slot_wrap;
    logic          dig_wrap;
    logic          col_wrap;

    // Digit buffers: pending holds the last load, active is what is shown
    logic [4*N_DIGITS-1:0] dig_act_q, dig_act_d;
    logic [4*N_DIGITS-1:0] dig_pend_q, dig_pend_d;
    logic                  dig_pflag_q, dig_pflag_d;

    // Matrix buffers, same scheme keyed on the column wrap
    logic [ROWS*COLS-1:0]  mat_act_q, mat_act_d;
    logic [ROWS*COLS-1:0]  mat_pend_q, mat_pend_d;
    logic                  mat_pflag_q, mat_pflag_d;

    // Registered outputs and their next values
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] den_q, den_d;
    logic [ROWS-1:0]     row_q, row_d;
    logic [COLS-1:0]     cen_q, cen_d;
    logic                dfr_q, mfr_q;

    logic                blank;
    logic [3:0]          cur_hex;
    logic [ROWS-1:0]     cur_row;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is never lit
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Slot timer and scan index advance; both indices step on the same wrap
    always_comb begin
        slot_wrap = (t_q == T_LAST);
        dig_wrap  = slot_wrap && (dig_idx_q == DIG_LAST);
        col_wrap  = slot_wrap && (col_idx_q == COL_LAST);
        t_d       = slot_wrap ? '0 : t_q + 1'b1;
        dig_idx_d = dig_idx_q;
        col_idx_d = col_idx_q;
        if (slot_wrap) begin
            dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
        end
    end

    // Digit double buffer: swap only at the digit frame boundary. A load that
    // lands on the boundary itself skips the pending stage entirely.
    always_comb begin
        dig_act_d   = dig_act_q;
        dig_pend_d  = dig_pend_q;
        dig_pflag_d = dig_pflag_q;
        if (dig_wrap) begin
            dig_pflag_d = 1'b0;
            if (digit_load) begin
                dig_act_d = digit_data;
            end else if (dig_pflag_q) begin
                dig_act_d = dig_pend_q;
            end
        end else if (digit_load) begin
            dig_pend_d  = digit_data;
            dig_pflag_d = 1'b1;
        end
    end

    // Matrix double buffer, swapped at the column frame boundary
    always_comb begin
        mat_act_d   = mat_act_q;
        mat_pend_d  = mat_pend_q;
        mat_pflag_d = mat_pflag_q;
        if (col_wrap) begin
            mat_pflag_d = 1'b0;
            if (matrix_load) begin
                mat_act_d = matrix_data;
            end else if (mat_pflag_q) begin
                mat_act_d = mat_pend_q;
            end
        end else if (matrix_load) begin
            mat_pend_d  = matrix_data;
            mat_pflag_d = 1'b1;
        end
    end

    // Output selection from the current slot; blanking forces everything off
    always_comb begin
        blank   = int'(t_q) < BLANK;
        cur_hex = 4'h0;
        cur_row = '0;
        den_d   = '1;
        cen_d   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dig_idx_q == DW'(i)) begin
                cur_hex = dig_act_q[i*4 +: 4];
                den_d[i] = blank;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_idx_q == CW'(c)) begin
                cur_row = mat_act_q[c*ROWS +: ROWS];
                cen_d[c] = blank;
            end
        end
        seg_d = blank ? 8'hFF : hex_to_seg(cur_hex);
        row_d = blank ? '0 : cur_row;
    end

    // Scan counters
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            t_q       <= '0;
            dig_idx_q <= '0;
            col_idx_q <= '0;
        end else begin
            t_q       <= t_d;
            dig_idx_q <= dig_idx_d;
            col_idx_q <= col_idx_d;
        end
    end

    // Frame buffers and pending flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dig_act_q   <= '0;
            dig_pend_q  <= '0;
            dig_pflag_q <= 1'b0;
            mat_act_q   <= '0;
            mat_pend_q  <= '0;
            mat_pflag_q <= 1'b0;
        end else begin
            dig_act_q   <= dig_act_d;
            dig_pend_q  <= dig_pend_d;
            dig_pflag_q <= dig_pflag_d;
            mat_act_q   <= mat_act_d;
            mat_pend_q  <= mat_pend_d;
            mat_pflag_q <= mat_pflag_d;
        end
    end

    // Pin registers; frame pulses land in the cycle after the index wraps
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seg_q <= 8'hFF;
            den_q <= '1;
            row_q <= '0;
            cen_q <= '1;
            dfr_q <= 1'b0;
            mfr_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            den_q <= den_d;
            row_q <= row_d;
            cen_q <= cen_d;
            dfr_q <= dig_wrap;
            mfr_q <= col_wrap;
        end
    end

    assign seg_out     = seg_q;
    assign digit_en    = den_q;
    assign mat_row     = row_q;
    assign mat_col_en  = cen_q;
    assign dig_frame   = dfr_q;
    assign mat_frame   = mfr_q;
    assign dig_pending = dig_pflag_q;
    assign mat_pending = mat_pflag_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl with PRESCALE=4, BLANK=1, 4 digits, 7x5 matrix.
// The driver advances one clock per step and pushes the expected pin state;
// a monitor pops and compares on the falling edge.
module tb_disp_scan_ctrl;

    localparam int NDIG = 4;
    localparam int NR   = 7;
    localparam int NC   = 5;
    localparam int PS   = 4;
    localparam int BL   = 1;
    localparam int W    = 28;

    localparam logic [W-1:0] RST_EXP = {8'hFF, 4'hF, 7'h00, 5'h1F, 4'b0000};

    logic              clk;
    logic              clr;
    logic [4*NDIG-1:0] digit_data;
    logic              digit_load;
    logic [NR*NC-1:0]  matrix_data;
    logic              matrix_load;
    logic [7:0]        seg_out;
    logic [NDIG-1:0]   digit_en;
    logic [NR-1:0]     mat_row;
    logic [NC-1:0]     mat_col_en;
    logic              dig_frame;
    logic              mat_frame;
    logic              dig_pending;
    logic              mat_pending;

    disp_scan_ctrl #(
        .N_DIGITS(NDIG), .ROWS(NR), .COLS(NC), .PRESCALE(PS), .BLANK(BL)
    ) dut (
        .clk(clk), .clr(clr),
        .digit_data(digit_data), .digit_load(digit_load),
        .matrix_data(matrix_data), .matrix_load(matrix_load),
        .seg_out(seg_out), .digit_en(digit_en),
        .mat_row(mat_row), .mat_col_en(mat_col_en),
        .dig_frame(dig_frame), .mat_frame(mat_frame),
        .dig_pending(dig_pending), .mat_pending(mat_pending)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    event         mon_ev;

    logic [7:0] dec_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: edges since release, displayed and waiting frame data
    int               n_edges;
    logic [4*NDIG-1:0] m_dig_act, m_dig_pend;
    logic              m_dig_pf;
    logic [NR*NC-1:0]  m_mat_act, m_mat_pend;
    logic              m_mat_pf;

    task automatic push(input logic [W-1:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic model_clear();
        n_edges    = 0;
        m_dig_act  = '0;
        m_dig_pend = '0;
        m_dig_pf   = 1'b0;
        m_mat_act  = '0;
        m_mat_pend = '0;
        m_mat_pf   = 1'b0;
    endtask

    // One clock with the given strobes; pins after edge n show the state after n-1 edges
    task automatic step(input logic dl, input logic [4*NDIG-1:0] dd,
                        input logic ml, input logic [NR*NC-1:0] md);
        int m, t, s, di, ci;
        logic blank, dw, mw;
        logic [3:0] h;
        logic [7:0] seg;
        logic [NDIG-1:0] en;
        logic [NR-1:0] row;
        logic [NC-1:0] cen;
        digit_load  = dl;
        digit_data  = dd;
        matrix_load = ml;
        matrix_data = md;
        @(posedge clk);
        m  = n_edges;
        n_edges++;
        t  = m % PS;
        s  = m / PS;
        di = s % NDIG;
        ci = s % NC;
        blank = (t < BL);
        h   = m_dig_act[di*4 +: 4];
        seg = blank ? 8'hFF : dec_tab[h];
        en  = blank ? 4'hF : ~(4'b0001 << di);
        row = blank ? 7'h00 : m_mat_act[ci*NR +: NR];
        cen = blank ? 5'h1F : ~(5'b00001 << ci);
        dw  = (m % (PS*NDIG)) == (PS*NDIG - 1);
        mw  = (m % (PS*NC)) == (PS*NC - 1);
        if (dw) begin
            if (dl) m_dig_act = dd;
            else if (m_dig_pf) m_dig_act = m_dig_pend;
            m_dig_pf = 1'b0;
        end else if (dl) begin
            m_dig_pend = dd;
            m_dig_pf   = 1'b1;
        end
        if (mw) begin
            if (ml) m_mat_act = md;
            else if (m_mat_pf) m_mat_act = m_mat_pend;
            m_mat_pf = 1'b0;
        end else if (ml) begin
            m_mat_pend = md;
            m_mat_pf   = 1'b1;
        end
        push({seg, en, row, cen, dw, mw, m_dig_pf, m_mat_pf}, $sformatf("cyc%0d", m + 1));
        #1;
        digit_load  = 1'b0;
        matrix_load = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: compare whenever an expectation is queued
    initial begin
        logic [W-1:0] e, a;
        string tg;
        forever begin
            @(negedge clk or mon_ev);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                a  = {seg_out, digit_en, mat_row, mat_col_en,
                      dig_frame, mat_frame, dig_pending, mat_pending};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s actual seg=%h en=%b row=%h col_en=%b frm=%b%b pend=%b%b required seg=%h en=%b row=%h col_en=%b frm=%b%b pend=%b%b",
                             tg, a[27:20], a[19:16], a[15:9], a[8:4], a[3], a[2], a[1], a[0],
                             e[27:20], e[19:16], e[15:9], e[8:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        clr         = 1'b1;
        digit_data  = '0;
        digit_load  = 1'b0;
        matrix_data = '0;
        matrix_load = 1'b0;
        model_clear();
        #1 push(RST_EXP, "reset");
        @(negedge clk);
        #1 clr = 1'b0;

        // Free scan with all-zero digits: blank cycle then C0 each slot
        idle(40);

        // Mid-frame load, visible only from the next digit frame
        step(1'b1, 16'hA3F1, 1'b0, '0);
        idle(40);

        // Two loads in one frame: the second one wins
        while (n_edges % 16 != 2) idle(1);
        step(1'b1, 16'h1111, 1'b0, '0);
        idle(3);
        step(1'b1, 16'h2222, 1'b0, '0);
        idle(30);

        // Load landing exactly on the boundary goes straight to active
        while (n_edges % 16 != 15) idle(1);
        step(1'b1, 16'h5678, 1'b0, '0);
        idle(20);

        // Matrix: single pixel at row 6, column 4
        step(1'b0, '0, 1'b1, 35'h400000000);
        idle(50);

        // Asynchronous clear in the middle of a slot
        idle(2);
        @(negedge clk);
        #1 clr = 1'b1;
        #1 push(RST_EXP, "clr_async");
        -> mon_ev;
        #1;
        repeat (2) begin
            @(posedge clk);
            #1 push(RST_EXP, "clr_hold");
        end
        @(negedge clk);
        #1 clr = 1'b0;
        model_clear();

        // Restart from slot 0 with buffers cleared
        idle(24);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d queued required 0", exp_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Parametrised time-multiplexed display driver: N-digit 7-segment display plus ROWS x COLS LED matrix.
- Internal slot prescaler; per-slot blanking to suppress ghosting.
- Double-buffered (pending/active) frame data with load strobes; updates are applied only at frame boundaries.
- Sits between game logic (status, coordinate and board registers) and board pins; replaces the free-running 2-/3-bit scan counters and mux trees.

Parameters:
N_DIGITS, 4, number of 7-seg digits (>=1)
ROWS, 7, matrix rows driven in parallel
COLS, 5, matrix columns scanned (>=1)
PRESCALE, 50000, clk cycles per scan slot (>=2)
BLANK, 4, cycles at start of each slot with all enables off (0 <= BLANK < PRESCALE)

Ports:
clk  in  1  system clock
clr  in  1  reset; asynchronous, active-high
digit_data  in  4*N_DIGITS  hex code per digit; digit i = [4i+3:4i]
digit_load  in  1  1-cycle strobe: capture digit_data into pending buffer
matrix_data  in  ROWS*COLS  pixel (r,c) = bit [c*ROWS+r], 1 = lit
matrix_load  in  1  1-cycle strobe: capture matrix_data into pending buffer
seg_out  out  8  {dp,g,f,e,d,c,b,a}, active-low, dp always 1
digit_en  out  N_DIGITS  digit anodes, active-low, at most one low
mat_row  out  ROWS  row data of scanned column, active-high
mat_col_en  out  COLS  column enable, active-low, at most one low
dig_frame  out  1  1-cycle pulse when digit index wraps N_DIGITS-1 -> 0
mat_frame  out  1  1-cycle pulse when column index wraps COLS-1 -> 0
dig_pending  out  1  pending digit data not yet applied
mat_pending  out  1  pending matrix data not yet applied

Behaviour:
- Reset (clr=1, async):
  - t=0, dig_idx=0, col_idx=0; active and pending buffers = 0; pending flags = 0.
  - seg_out=8'hFF, digit_en all 1, mat_row=0, mat_col_en all 1, frame pulses 0.
- Slot timer t: 0..PRESCALE-1, increments every cycle, wraps to 0. On the wrap cycle (t=PRESCALE-1):
  - dig_idx advances mod N_DIGITS.
  - col_idx advances mod COLS.
- Frame pulses:
  - dig_frame asserts in the cycle after dig_idx moves N_DIGITS-1 -> 0.
  - mat_frame asserts in the cycle after col_idx moves COLS-1 -> 0.
  - With N_DIGITS=1 or COLS=1, the corresponding pulse fires every slot.
- All outputs are registered, one cycle latency from internal state (t, indices, active buffers).
- Blanking:
  - While t < BLANK: digit_en and mat_col_en all 1; seg_out=8'hFF; mat_row=0.
  - Otherwise: digit_en[dig_idx]=0, mat_col_en[col_idx]=0, seg_out=decode(active digit dig_idx), mat_row=active column col_idx.
- Decode (hex -> seg_out):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- Loads:
  - digit_load copies digit_data to the pending buffer and sets dig_pending.
  - A second load before application overwrites the first (last wins).
- Application:
  - Pending digits move to active on the slot-wrap cycle where dig_idx goes N_DIGITS-1 -> 0; dig_pending clears in that cycle.
  - If digit_load coincides with that cycle, the incoming digit_data goes directly to active and dig_pending stays 0.
  - Matrix uses identical rules with col_idx wrap, matrix_load and mat_pending.
- Loads never disturb t or the indices. A frame is never shown with mixed old/new data.
- clr mid-frame aborts immediately: buffers are lost and scanning restarts at slot 0 after release.

Test Plan:
- Reset then release, PRESCALE=4, BLANK=1, N_DIGITS=4, COLS=5 -> digit_en sequence per slot 1111 then 1110 x3. Next slot 1101. dig_frame pulses once every 16 cycles.
- Active digits 0 (after reset) -> seg_out=C0 in each unblanked cycle; seg_out=FF and digit_en=1111 in each blank cycle.
- digit_load with data 16'hA3F1 mid-frame -> dig_pending=1 until the next wrap. Then digits 0..3 show F9,8E,B0,88; no slot before the wrap shows the new data.
- Two digit_loads (16'h1111 then 16'h2222) in one frame -> only A4 is displayed after the boundary.
- digit_load coincident with the wrap cycle -> new data visible from slot 0 of the new frame; dig_pending never rises.
- matrix_load with only pixel (r=6,c=4) set -> mat_row=7'h40 while mat_col_en=01111, else mat_row=0. Assert clr mid-slot -> all outputs return to their reset values asynchronously.
